// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - parametrised serial pattern detector with KMP next-state table
// Moore flag on full match, sample enable, saturating match counter.
module seq_detector_param #(
  parameter int                     PATTERN_LEN = 4,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1101,
  parameter bit                     OVERLAP     = 1'b1,
  parameter int                     CNT_W       = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               en,
  input  logic                               w,
  input  logic                               cnt_clr,
  output logic                               z,
  output logic [CNT_W-1:0]                   match_cnt,
  output logic [$clog2(PATTERN_LEN+1)-1:0]   state
);

  localparam int SW   = $clog2(PATTERN_LEN + 1);
  localparam int TBLW = 2 * (PATTERN_LEN + 1) * SW;
  localparam logic [SW-1:0]    S_FULL  = SW'(PATTERN_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Entry {s, bit} holds the longest pattern prefix that is a suffix of prefix(s) followed by bit.
  function automatic logic [TBLW-1:0] build_next_tbl();
    logic [TBLW-1:0]        tbl;
    logic [PATTERN_LEN-1:0] sh_a;
    logic [PATTERN_LEN-1:0] sh_b;
    logic                   seq_bit;
    logic                   ok;
    int                     best;
    int                     j;
    tbl = '0;
    for (int s = 0; s <= PATTERN_LEN; s++) begin
      for (int b = 0; b < 2; b++) begin
        best = 0;
        for (int k = 1; k <= PATTERN_LEN; k++) begin
          if (k <= s + 1) begin
            ok = 1'b1;
            for (int m = 0; m < k; m++) begin
              j = s + 1 - k + m;
              if (j == s) begin
                seq_bit = (b == 1);
              end else begin
                sh_a    = PATTERN >> (PATTERN_LEN - 1 - j);
                seq_bit = sh_a[0];
              end
              sh_b = PATTERN >> (PATTERN_LEN - 1 - m);
              if (seq_bit != sh_b[0]) ok = 1'b0;
            end
            if (ok) best = k;
          end
        end
        tbl = tbl | (TBLW'(best) << ((2 * s + b) * SW));
      end
    end
    return tbl;
  endfunction

  localparam logic [TBLW-1:0] NEXT_TBL = build_next_tbl();

  logic [SW-1:0]    r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [SW:0]      w_idx;
  logic [SW-1:0]    w_kmp;
  logic [SW-1:0]    w_from0;
  logic [SW-1:0]    w_next;

  always_ff @(posedge clk) begin
    if (rst) r_state <= '0;
    else     r_state <= w_next;
  end

  always_comb begin
    w_idx   = {r_state, w};
    w_kmp   = SW'(NEXT_TBL >> (int'(w_idx) * SW));
    w_from0 = SW'(NEXT_TBL >> (int'(w) * SW));
    w_next  = r_state;
    if (en) begin
      if (r_state > S_FULL)                    w_next = '0;
      else if (r_state == S_FULL && !OVERLAP)  w_next = w_from0;
      else                                     w_next = w_kmp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                              r_cnt <= '0;
    else if (cnt_clr)                                     r_cnt <= '0;
    else if (en && w_next == S_FULL && r_cnt != CNT_MAX)  r_cnt <= r_cnt + CNT_W'(1);
  end

  always_comb begin
    z         = (r_state == S_FULL);
    state     = r_state;
    match_cnt = r_cnt;
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - directed vector bench for seq_detector_param
// Three instances: 1101 overlapping, 1101 non-overlapping with 2-bit counter, 1111 overlapping.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst, en, w, cnt_clr;
  logic       z_o, z_n, z_1;
  logic [7:0] c_o, c_1;
  logic [1:0] c_n;
  logic [2:0] s_o, s_n, s_1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_detector_param #(.PATTERN_LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(8)) u_ovl (
    .clk(clk), .rst(rst), .en(en), .w(w), .cnt_clr(cnt_clr),
    .z(z_o), .match_cnt(c_o), .state(s_o));

  seq_detector_param #(.PATTERN_LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b0), .CNT_W(2)) u_nov (
    .clk(clk), .rst(rst), .en(en), .w(w), .cnt_clr(cnt_clr),
    .z(z_n), .match_cnt(c_n), .state(s_n));

  seq_detector_param #(.PATTERN_LEN(4), .PATTERN(4'b1111), .OVERLAP(1'b1), .CNT_W(8)) u_ones (
    .clk(clk), .rst(rst), .en(en), .w(w), .cnt_clr(cnt_clr),
    .z(z_1), .match_cnt(c_1), .state(s_1));

  typedef struct {
    int rst, en, w, clr;
    int zo, so, co;
    int zn, sn, cn;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int r, input int e, input int ww, input int c,
                              input int zo, input int so, input int co,
                              input int zn, input int sn, input int cn);
    vec_t v;
    v.rst = r; v.en = e; v.w = ww; v.clr = c;
    v.zo = zo; v.so = so; v.co = co;
    v.zn = zn; v.sn = sn; v.cn = cn;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic ww, input logic c);
    @(negedge clk);
    rst = r; en = e; w = ww; cnt_clr = c;
    @(posedge clk);
    #1;
  endtask

  int bits[4] = '{1, 1, 0, 1};

  initial begin
    rst = 1'b1; en = 1'b0; w = 1'b0; cnt_clr = 1'b0;
    repeat (2) @(posedge clk);

    //          rst en w clr   z  s  c (ovl)   z  s  c (non-ovl)
    vecs.push_back(mk(1, 0, 0, 0,  0, 0, 0,  0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0,  0, 1, 0,  0, 1, 0));
    vecs.push_back(mk(0, 1, 1, 0,  0, 2, 0,  0, 2, 0));
    vecs.push_back(mk(0, 1, 0, 0,  0, 3, 0,  0, 3, 0));
    vecs.push_back(mk(0, 1, 1, 0,  1, 4, 1,  1, 4, 1));
    vecs.push_back(mk(0, 1, 1, 0,  0, 2, 1,  0, 1, 1));
    vecs.push_back(mk(0, 1, 0, 0,  0, 3, 1,  0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0,  1, 4, 2,  0, 1, 1));
    vecs.push_back(mk(1, 1, 1, 1,  0, 0, 0,  0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0,  0, 1, 0,  0, 1, 0));
    vecs.push_back(mk(0, 1, 1, 0,  0, 2, 0,  0, 2, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 2, 0,  0, 2, 0));
    vecs.push_back(mk(0, 0, 1, 0,  0, 2, 0,  0, 2, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 2, 0,  0, 2, 0));
    vecs.push_back(mk(0, 1, 0, 0,  0, 3, 0,  0, 3, 0));
    vecs.push_back(mk(0, 1, 1, 0,  1, 4, 1,  1, 4, 1));
    vecs.push_back(mk(0, 0, 1, 1,  1, 4, 0,  1, 4, 0));
    vecs.push_back(mk(0, 0, 0, 0,  1, 4, 0,  1, 4, 0));
    vecs.push_back(mk(1, 0, 0, 0,  0, 0, 0,  0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0,  0, 1, 0,  0, 1, 0));
    vecs.push_back(mk(0, 1, 1, 0,  0, 2, 0,  0, 2, 0));
    vecs.push_back(mk(0, 1, 0, 0,  0, 3, 0,  0, 3, 0));
    vecs.push_back(mk(1, 0, 1, 0,  0, 0, 0,  0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0,  0, 1, 0,  0, 1, 0));

    foreach (vecs[i]) begin
      step(1'(vecs[i].rst), 1'(vecs[i].en), 1'(vecs[i].w), 1'(vecs[i].clr));
      check($sformatf("v%0d z_ovl", i),     int'(z_o), vecs[i].zo);
      check($sformatf("v%0d state_ovl", i), int'(s_o), vecs[i].so);
      check($sformatf("v%0d cnt_ovl", i),   int'(c_o), vecs[i].co);
      check($sformatf("v%0d z_nov", i),     int'(z_n), vecs[i].zn);
      check($sformatf("v%0d state_nov", i), int'(s_n), vecs[i].sn);
      check($sformatf("v%0d cnt_nov", i),   int'(c_n), vecs[i].cn);
    end

    // Counter saturation on the 2-bit instance, then clear colliding with a match.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int rep = 0; rep < 5; rep++) begin
      for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'(bits[k]), 1'b0);
      check($sformatf("sat%0d z_nov", rep),   int'(z_n), 1);
      check($sformatf("sat%0d cnt_nov", rep), int'(c_n), (rep < 3) ? rep + 1 : 3);
    end
    check("sat cnt_ovl", int'(c_o), 5);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'(bits[k]), 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check("clr_vs_match z_nov",   int'(z_n), 1);
    check("clr_vs_match cnt_nov", int'(c_n), 0);
    check("clr_vs_match z_ovl",   int'(z_o), 1);
    check("clr_vs_match cnt_ovl", int'(c_o), 0);

    // All-ones pattern must self-loop on the full state.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0);
      check($sformatf("ones%0d z", i),     int'(z_1), (i >= 3) ? 1 : 0);
      check($sformatf("ones%0d state", i), int'(s_1), (i < 3) ? i + 1 : 4);
      check($sformatf("ones%0d cnt", i),   int'(c_1), (i < 3) ? 0 : i - 2);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("ones_break z",     int'(z_1), 0);
    check("ones_break state", int'(s_1), 0);
    check("ones_break cnt",   int'(c_1), 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
